// File: rtl/logger_pack16_32_393_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | logger_pack16_32_393_if : halfword input / packed word output    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface logger_pack16_32_393_if;
   logic [15:0] din;
   logic        din_stb;
   logic [31:0] dout;
   logic        dout_valid;
   logic        dout_last;
   logic        dout_ready;

   modport master (
      output din, din_stb, dout_ready,
      input  dout, dout_valid, dout_last
   );

   modport slave (
      input  din, din_stb, dout_ready,
      output dout, dout_valid, dout_last
   );
endinterface
`default_nettype wire

// File: rtl/logger_pack16_32_393.sv
`default_nettype none
// +------------------------------------------------------------------+
// | logger_pack16_32_393 : 16->32 record packer with FWFT FIFO,      |
// | whole-record drop on overflow. Rev 1.0                           |
// +------------------------------------------------------------------+
module logger_pack16_32_393 #(
   parameter int REC_WORDS32 = 16,
   parameter int FIFO_LOG2   = 4
) (
   input  wire logic               mclk,
   input  wire logic               rst,
   input  wire logic               en,
   input  wire logic               clr_overflow,
   output logic                    overflow,
   output logic [15:0]             rec_cnt,
   logger_pack16_32_393_if.slave   bus
);

   localparam int c_DEPTH  = 1 << FIFO_LOG2;
   localparam int c_WIDX_W = $clog2(REC_WORDS32);
   localparam logic [c_WIDX_W-1:0] c_LAST_IDX = c_WIDX_W'(REC_WORDS32 - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PACK = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_hph;
   logic [c_WIDX_W-1:0]   r_widx;
   logic [15:0]           r_low;
   logic [32:0]           r_mem [c_DEPTH];
   logic [FIFO_LOG2-1:0]  r_wptr;
   logic [FIFO_LOG2-1:0]  r_rptr;
   logic [FIFO_LOG2:0]    r_count;

   logic        w_accept;
   logic        w_push;
   logic        w_pop;
   logic        w_drop_entry;
   logic        w_rec_first;
   logic        w_rec_end;
   logic        w_last;
   logic        w_room;
   logic [31:0] w_free;

   assign w_accept    = bus.din_stb && (r_state != S_IDLE);
   assign w_last      = (r_widx == c_LAST_IDX);
   assign w_rec_first = !r_hph && (r_widx == '0);
   assign w_rec_end   = r_hph && w_last;
   // Whole-record reservation: the pop in this same cycle is deliberately ignored.
   assign w_free      = 32'(c_DEPTH) - 32'(r_count);
   assign w_room      = (w_free >= 32'(REC_WORDS32));

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_push       = 1'b0;
      w_drop_entry = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (en) w_next = S_PACK;
         end
         S_PACK: begin
            if (bus.din_stb) begin
               if (w_rec_first && !w_room) begin
                  w_drop_entry = 1'b1;
                  w_next       = S_DROP;
               end else begin
                  w_push = r_hph;
                  if (w_rec_end && !en) w_next = S_IDLE;
               end
            end
         end
         S_DROP: begin
            if (bus.din_stb && w_rec_end) w_next = en ? S_PACK : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         r_hph  <= 1'b0;
         r_widx <= '0;
         r_low  <= '0;
      end else if (r_state == S_IDLE) begin
         r_hph  <= 1'b0;
         r_widx <= '0;
      end else if (w_accept) begin
         r_hph <= ~r_hph;
         if (!r_hph) begin
            r_low <= bus.din;
         end else begin
            r_widx <= w_last ? '0 : r_widx + c_WIDX_W'(1);
         end
      end
   end

   always_ff @(posedge mclk) begin
      if (w_push) r_mem[r_wptr] <= {w_last, bus.din, r_low};
   end

   assign w_pop          = bus.dout_valid && bus.dout_ready;
   assign bus.dout_valid = (r_count != '0);
   // Gate the head with valid so the outputs read zero whenever the FIFO is empty.
   assign bus.dout       = bus.dout_valid ? r_mem[r_rptr][31:0] : 32'd0;
   assign bus.dout_last  = bus.dout_valid ? r_mem[r_rptr][32] : 1'b0;

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + FIFO_LOG2'(1);
         if (w_pop)  r_rptr <= r_rptr + FIFO_LOG2'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (FIFO_LOG2 + 1)'(1);
            2'b01:   r_count <= r_count - (FIFO_LOG2 + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
         rec_cnt  <= '0;
      end else begin
         if (w_drop_entry)      overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
         if (w_push && w_last)  rec_cnt  <= rec_cnt + 16'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_logger_pack16_32_393.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_logger_pack16_32_393 : randomized bench with record-level     |
// | reference model. Rev 1.0                                         |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_logger_pack16_32_393;
   localparam int REC   = 16;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic        clr = 1'b0;
   logic        overflow;
   logic [15:0] rec_cnt;

   logger_pack16_32_393_if bus();

   logger_pack16_32_393 #(.REC_WORDS32(REC), .FIFO_LOG2(4)) dut (
      .mclk(clk), .rst(rst), .en(en), .clr_overflow(clr),
      .overflow(overflow), .rec_cnt(rec_cnt), .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int valid_err = 0;
   int hold_err = 0;

   logic [32:0] ref_fifo[$];
   logic [32:0] obs_q[$];
   logic [32:0] exp_q[$];

   // Model: 0 = idle, 1 = packing, 2 = dropping; m_hcnt = halfword index in record.
   int          m_state;
   int          m_hcnt;
   logic [15:0] m_low;
   logic        m_ovf;
   logic [15:0] m_rec;
   logic        prev_stall;
   logic [32:0] prev_word;

   task automatic model_reset();
      m_state = 0; m_hcnt = 0; m_low = '0; m_ovf = 1'b0; m_rec = '0;
      prev_stall = 1'b0; prev_word = '0;
      ref_fifo.delete(); obs_q.delete(); exp_q.delete();
   endtask

   task automatic clear_obs();
      obs_q.delete(); exp_q.delete(); valid_err = 0; hold_err = 0;
   endtask

   // One clock cycle: drive inputs at negedge, log pops, advance the model, land on next negedge.
   task automatic cycle(input logic en_i, input logic stb_i, input logic [15:0] d_i,
                        input logic rdy_i, input logic clr_i);
      int sz;
      en = en_i; bus.din_stb = stb_i; bus.din = d_i; bus.dout_ready = rdy_i; clr = clr_i;
      sz = ref_fifo.size();
      if (bus.dout_valid !== (sz != 0)) valid_err++;
      if (prev_stall && ({bus.dout_last, bus.dout} !== prev_word)) hold_err++;
      if (bus.dout_valid === 1'b1 && rdy_i) begin
         obs_q.push_back({bus.dout_last, bus.dout});
         if (sz != 0) exp_q.push_back(ref_fifo.pop_front());
         else         exp_q.push_back(33'bx);
      end
      prev_stall = (bus.dout_valid === 1'b1) && !rdy_i;
      prev_word  = {bus.dout_last, bus.dout};
      case (m_state)
         0: if (en_i) m_state = 1;
         1: if (stb_i) begin
               if (m_hcnt == 0 && (DEPTH - sz) < REC) begin
                  m_state = 2; m_hcnt = 1; m_ovf = 1'b1;
               end else begin
                  if (m_hcnt % 2 == 0) m_low = d_i;
                  else begin
                     ref_fifo.push_back({(m_hcnt == 2*REC-1), d_i, m_low});
                     if (m_hcnt == 2*REC-1) m_rec++;
                  end
                  m_hcnt++;
                  if (m_hcnt == 2*REC) begin
                     m_hcnt = 0;
                     if (!en_i) m_state = 0;
                  end
               end
            end
         default: if (stb_i) begin
               m_hcnt++;
               if (m_hcnt == 2*REC) begin
                  m_hcnt = 0; m_state = en_i ? 1 : 0;
               end
            end
      endcase
      if (clr_i && !(m_state == 2 && m_hcnt == 1 && stb_i)) m_ovf = 1'b0;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic idle_cycles(input int n, input logic en_i);
      for (int i = 0; i < n; i++) cycle(en_i, 1'b0, 16'h0, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.dout_valid); end
      checks++; if (bus.dout !== 32'd0) begin failures++; $display("FAIL reset_dout got=%h exp=0", bus.dout); end
      checks++; if (bus.dout_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", bus.dout_last); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      checks++; if (rec_cnt !== 16'd0) begin failures++; $display("FAIL reset_rec_cnt got=%0d exp=0", rec_cnt); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic_pack();
      logic [32:0] lit;
      clear_obs();
      cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1, 16'(i), 1'b1, 1'b0);
      idle_cycles(4, 1'b1);
      checks++; if (obs_q.size() != 16) begin failures++; $display("FAIL basic_count got=%0d exp=16", obs_q.size()); end
      for (int i = 0; i < obs_q.size() && i < 16; i++) begin
         lit = {(i == 15), 16'(2*i+1), 16'(2*i)};
         checks++;
         if (obs_q[i] !== lit || obs_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL basic_word[%0d] got=%h exp=%h", i, obs_q[i], lit);
         end
      end
      checks++; if (rec_cnt !== 16'd1) begin failures++; $display("FAIL basic_rec_cnt got=%0d exp=1", rec_cnt); end
      checks++; if (valid_err != 0) begin failures++; $display("FAIL basic_valid errors=%0d exp=0", valid_err); end
   endtask

   task automatic test_back_to_back();
      logic rdy = 1'b1;
      clear_obs();
      for (int i = 0; i < 64; i++) begin
         cycle(1'b1, 1'b1, 16'($urandom), rdy, 1'b0);
         rdy = ~rdy;
      end
      idle_cycles(40, 1'b1);
      checks++; if (obs_q.size() != exp_q.size() || ref_fifo.size() != 0) begin
         failures++; $display("FAIL b2b_count got=%0d exp=%0d left=%0d", obs_q.size(), exp_q.size(), ref_fifo.size()); end
      for (int i = 0; i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_word[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      end
      checks++; if (hold_err != 0 || valid_err != 0) begin
         failures++; $display("FAIL b2b_stall hold_err=%0d valid_err=%0d exp=0", hold_err, valid_err); end
      checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL b2b_overflow got=%b exp=%b", overflow, m_ovf); end
      checks++; if (rec_cnt !== m_rec) begin failures++; $display("FAIL b2b_rec_cnt got=%0d exp=%0d", rec_cnt, m_rec); end
   endtask

   task automatic test_overflow_drop();
      logic [15:0] rec0;
      clr = 1'b1; cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
      clear_obs();
      rec0 = rec_cnt;
      // Clear is requested in the very cycle the second record is refused.
      for (int i = 0; i < 64; i++) cycle(1'b1, 1'b1, 16'($urandom), 1'b0, (i == 32));
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_priority got=%b exp=1", overflow); end
      checks++; if (rec_cnt !== rec0 + 16'd1) begin failures++; $display("FAIL ovf_rec_cnt got=%0d exp=%0d", rec_cnt, rec0 + 16'd1); end
      idle_cycles(20, 1'b1);
      for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1, 16'($urandom), 1'b1, 1'b0);
      idle_cycles(6, 1'b1);
      checks++; if (obs_q.size() != 32) begin failures++; $display("FAIL ovf_count got=%0d exp=32", obs_q.size()); end
      for (int i = 0; i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i] || obs_q[i][32] !== (i == 15 || i == 31)) begin
            failures++; $display("FAIL ovf_word[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++; if (rec_cnt !== rec0 + 16'd2) begin failures++; $display("FAIL ovf_rec_cnt2 got=%0d exp=%0d", rec_cnt, rec0 + 16'd2); end
      cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
   endtask

   task automatic test_enable_mid();
      logic [15:0] rec0;
      clear_obs();
      rec0 = rec_cnt;
      for (int i = 0; i < 32; i++) cycle((i <= 5), 1'b1, 16'($urandom), 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 16'($urandom), 1'b1, 1'b0);
      idle_cycles(4, 1'b0);
      checks++; if (obs_q.size() != 16) begin failures++; $display("FAIL en_count got=%0d exp=16", obs_q.size()); end
      for (int i = 0; i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL en_word[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      end
      checks++; if (rec_cnt !== rec0 + 16'd1) begin failures++; $display("FAIL en_rec_cnt got=%0d exp=%0d", rec_cnt, rec0 + 16'd1); end
      checks++; if (bus.dout_valid !== 1'b0 || valid_err != 0) begin
         failures++; $display("FAIL en_ignored valid=%b valid_err=%0d exp=0", bus.dout_valid, valid_err); end
   endtask

   task automatic test_async_reset();
      logic [15:0] hw[32];
      cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 16'($urandom), 1'b0, 1'b0);
      bus.din_stb = 1'b1; bus.din = 16'h5A5A;
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.dout_valid !== 1'b0 || bus.dout !== 32'd0 || bus.dout_last !== 1'b0) begin
         failures++; $display("FAIL arst_outputs valid=%b dout=%h last=%b exp=0", bus.dout_valid, bus.dout, bus.dout_last); end
      checks++; if (rec_cnt !== 16'd0 || overflow !== 1'b0) begin
         failures++; $display("FAIL arst_regs rec_cnt=%0d overflow=%b exp=0", rec_cnt, overflow); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      clear_obs();
      cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 32; i++) begin
         hw[i] = 16'($urandom);
         cycle(1'b1, 1'b1, hw[i], 1'b1, 1'b0);
      end
      idle_cycles(4, 1'b1);
      checks++; if (obs_q.size() != 16) begin failures++; $display("FAIL arst_count got=%0d exp=16", obs_q.size()); end
      checks++; if (obs_q.size() > 0 && obs_q[0] !== {1'b0, hw[1], hw[0]}) begin
         failures++; $display("FAIL arst_align got=%h exp=%h", obs_q[0], {1'b0, hw[1], hw[0]}); end
      for (int i = 0; i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL arst_word[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      end
      checks++; if (rec_cnt !== 16'd1) begin failures++; $display("FAIL arst_rec_cnt got=%0d exp=1", rec_cnt); end
   endtask

   task automatic test_random();
      clear_obs();
      for (int i = 0; i < 1500; i++)
         cycle(($urandom % 8) != 0, ($urandom % 4) != 0, 16'($urandom),
               ($urandom % 2) == 0, ($urandom % 16) == 0);
      idle_cycles(40, 1'b1);
      checks++; if (obs_q.size() != exp_q.size() || ref_fifo.size() != 0) begin
         failures++; $display("FAIL rnd_count got=%0d exp=%0d left=%0d", obs_q.size(), exp_q.size(), ref_fifo.size()); end
      for (int i = 0; i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_word[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      end
      checks++; if (hold_err != 0 || valid_err != 0) begin
         failures++; $display("FAIL rnd_protocol hold_err=%0d valid_err=%0d exp=0", hold_err, valid_err); end
      checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_overflow got=%b exp=%b", overflow, m_ovf); end
      checks++; if (rec_cnt !== m_rec) begin failures++; $display("FAIL rnd_rec_cnt got=%0d exp=%0d", rec_cnt, m_rec); end
   endtask

   initial begin
      bus.din = '0; bus.din_stb = 1'b0; bus.dout_ready = 1'b0;
      model_reset();
      test_reset();
      test_basic_pack();
      test_back_to_back();
      test_overflow_drop();
      test_enable_mid();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
